// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared constants and types for the divide controller.
//   - div_state_e : FSM state encoding (IDLE, SEND, WAIT, DONE, DRAIN)
//   - WordW/DataW : 32-bit operand word and 64-bit divider channel widths
//   - field offsets for {dividend, divisor} and {quotient, remainder}
package div_ctrl_pkg;

    localparam int unsigned WordW = 32;
    localparam int unsigned DataW = 64;

    // Operand channel packing: {dividend, divisor}
    localparam int unsigned DividendLsb = 32;
    localparam int unsigned DivisorLsb  = 0;

    // Result channel packing: {quotient, remainder}
    localparam int unsigned QuoLsb = 32;
    localparam int unsigned RemLsb = 0;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSend  = 3'd1,
        StWait  = 3'd2,
        StDone  = 3'd3,
        StDrain = 3'd4
    } div_state_e;

    function automatic logic [WordW-1:0] quotient_of(input logic [DataW-1:0] res);
        return res[QuoLsb +: WordW];
    endfunction

    function automatic logic [WordW-1:0] remainder_of(input logic [DataW-1:0] res);
        return res[RemLsb +: WordW];
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: sequences one divide instruction from the EXE stage through an external
// valid/ready divider and commits {quotient, remainder} to LO/HI exactly once.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   req_valid/req_signed        EXE holds a div (signed=1) or divu (signed=0)
//   req_dividend/req_divisor    rs / rt operand values
//   req_ack                     EXE advances; releases DONE
//   flush                       exception/eret cancels the EXE instruction
//   req_done                    result committed (es_ready_go for divides)
//   busy                        controller is not idle
//   div_s_valid/ready/signed/data  operand channel, data = {dividend, divisor}
//   div_m_valid/data            result channel, data = {quotient, remainder}
//   hi_we/lo_we/hi_wdata/lo_wdata  HI/LO write port (HI=remainder, LO=quotient)
//
// Build option: DIV_ZERO_FAST_EN -- a zero divisor bypasses the divider and commits
// LO=32'hFFFFFFFF, HI=dividend straight from IDLE.
//
// All outputs are registered. A flushed instruction whose operands were already
// accepted by the divider parks in DRAIN until the orphan result returns, so it
// cannot be mistaken for the result of the next divide.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic             req_signed,
    input  logic [WordW-1:0] req_dividend,
    input  logic [WordW-1:0] req_divisor,
    input  logic             req_ack,
    input  logic             flush,
    output logic             req_done,
    output logic             busy,
    output logic             div_s_valid,
    input  logic             div_s_ready,
    output logic             div_s_signed,
    output logic [DataW-1:0] div_s_data,
    input  logic             div_m_valid,
    input  logic [DataW-1:0] div_m_data,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WordW-1:0] hi_wdata,
    output logic [WordW-1:0] lo_wdata
);

    div_state_e       state_q, state_d;
    logic [WordW-1:0] dividend_q, dividend_d;
    logic [WordW-1:0] divisor_q, divisor_d;
    logic             signed_q, signed_d;
    logic             s_valid_q, s_valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             we_q, we_d;
    logic [WordW-1:0] hi_wdata_q, hi_wdata_d;
    logic [WordW-1:0] lo_wdata_q, lo_wdata_d;

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signed_d   = signed_q;
        hi_wdata_d = hi_wdata_q;
        lo_wdata_d = lo_wdata_q;
        we_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && !flush) begin
                    dividend_d = req_dividend;
                    divisor_d  = req_divisor;
                    signed_d   = req_signed;
`ifdef DIV_ZERO_FAST_EN
                    if (req_divisor == '0) begin
                        state_d    = StDone;
                        we_d       = 1'b1;
                        lo_wdata_d = '1;
                        hi_wdata_d = req_dividend;
                    end else begin
                        state_d = StSend;
                    end
`else
                    state_d = StSend;
`endif
                end
            end
            StSend: begin
                // Once the divider has taken the operands a result is owed,
                // so a flush on the handshake cycle must still drain it.
                if (div_s_ready) begin
                    state_d = flush ? StDrain : StWait;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = div_m_valid ? StIdle : StDrain;
                end else if (div_m_valid) begin
                    state_d    = StDone;
                    we_d       = 1'b1;
                    lo_wdata_d = quotient_of(div_m_data);
                    hi_wdata_d = remainder_of(div_m_data);
                end
            end
            StDone: begin
                if (req_ack || flush) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (div_m_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        s_valid_d = (state_d == StSend);
        done_d    = (state_d == StDone);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            s_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            hi_wdata_q <= '0;
            lo_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signed_q   <= signed_d;
            s_valid_q  <= s_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
            hi_wdata_q <= hi_wdata_d;
            lo_wdata_q <= lo_wdata_d;
        end
    end

    assign req_done     = done_q;
    assign busy         = busy_q;
    assign div_s_valid  = s_valid_q;
    assign div_s_signed = signed_q;
    assign div_s_data   = {dividend_q, divisor_q};
    assign hi_we        = we_q;
    assign lo_we        = we_q;
    assign hi_wdata     = hi_wdata_q;
    assign lo_wdata     = lo_wdata_q;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: EXE stage holds a valid divide instruction.
REQ-004 SHALL have port req_signed, input, 1 bit: 1 = div, 0 = divu.
REQ-005 SHALL have ports req_dividend and req_divisor, input, 32 bits each: rs and rt values.
REQ-006 SHALL have port req_ack, input, 1 bit: EXE stage advances (es_to_ms_valid && ms_allowin).
REQ-007 SHALL have port flush, input, 1 bit: exception or eret cancel of the EXE instruction.
REQ-008 SHALL have port req_done, output, 1 bit: result committed; drives es_ready_go for divides.
REQ-009 SHALL have port busy, output, 1 bit: FSM is not IDLE.
REQ-010 SHALL have ports div_s_valid (output, 1 bit), div_s_ready (input, 1 bit), div_s_signed (output, 1 bit) and div_s_data (output, 64 bits, {dividend, divisor}): divider operand channel.
REQ-011 SHALL have ports div_m_valid (input, 1 bit) and div_m_data (input, 64 bits, {quotient, remainder}): divider result channel.
REQ-012 SHALL have ports hi_we and lo_we (output, 1 bit each) and hi_wdata and lo_wdata (output, 32 bits each): HI/LO write port.

Function
REQ-013 SHALL implement the FSM states IDLE, SEND, WAIT, DONE and DRAIN.
REQ-014 SHALL transition IDLE->SEND on req_valid && !flush, and SHALL latch the operands and req_signed in that cycle; later operand changes SHALL be ignored.
REQ-015 SHALL assert div_s_valid only in SEND, with div_s_data and div_s_signed taken from the latched copies.
REQ-016 SHALL transition SEND->WAIT on div_s_ready && !flush, SEND->IDLE on !div_s_ready && flush, and SEND->DRAIN on div_s_ready && flush.
REQ-017 SHALL, in WAIT, on div_m_valid && !flush, pulse hi_we and lo_we for exactly one cycle with LO=quotient and HI=remainder, and then enter DONE.
REQ-018 SHALL transition WAIT->DRAIN on flush without div_m_valid, and WAIT->IDLE on flush with div_m_valid, writing nothing to HI/LO.
REQ-019 SHALL hold req_done=1 throughout DONE and SHALL exit to IDLE on req_ack or flush; a flush in DONE SHALL NOT undo the HI/LO write.
REQ-020 SHALL, in DRAIN, discard the result on div_m_valid and go to IDLE; requests SHALL NOT be accepted in DRAIN.
REQ-021 SHALL keep req_done and all write enables 0 in every state other than those named in REQ-017 and REQ-019.
REQ-022 SHALL have minimum latency: request to req_done = divider latency + 2 cycles.
REQ-023 SHALL NOT raise an exception on divide-by-zero; without the option of REQ-026, the divider output is committed unchanged.

Reset
REQ-024 SHALL, while resetn=0, force the FSM to IDLE and drive every output to 0, including div_s_data, hi_wdata and lo_wdata.
REQ-025 SHALL, on reset mid-operation, not drain: the parent also resets the divider.

Configuration
REQ-026 SHALL, with macro DIV_ZERO_FAST_EN defined, handle divisor==0 as IDLE->DONE directly, with no divider transaction, lo_wdata=32'hFFFFFFFF, hi_wdata=dividend, and the write pulsed in the IDLE->DONE cycle.
REQ-027 SHALL, without DIV_ZERO_FAST_EN, route divisor==0 through the divider like any other operand.

Structure
REQ-028 SHALL take the FSM state encoding, the 64-bit operand/result width constants and the {quotient, remainder} field offsets from the shared mycpu package/header.
REQ-029 SHALL contain no sub-module; the divider IP and the HI/LO registers are instantiated by the parent EXE stage.

Verification
REQ-030 SHALL cover: divu 100/7, s_ready at once, 10-cycle divider -> one write pulse, LO=14, HI=2, req_done 12 cycles after req_valid.
REQ-031 SHALL cover: div -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF, div_s_signed=1.
REQ-032 SHALL cover: flush in the third WAIT cycle -> DRAIN, result discarded, hi_we never 1, then IDLE.
REQ-033 SHALL cover: flush in the same cycle as div_s_ready -> DRAIN; with flush and no ready -> IDLE and div_s_valid drops the next cycle.
REQ-034 SHALL cover: req_ack held 0 for 5 cycles in DONE -> req_done stays 1 and exactly one write pulse occurs.
REQ-035 SHALL cover: with DIV_ZERO_FAST_EN, divisor 0 and dividend 5 -> req_done next cycle, LO=32'hFFFFFFFF, HI=5, div_s_valid never 1.
